alsu_issue_ctrl: RTL

- Initiator-side controller for the 4-bit arithmetic/logic/shift unit (ALSU).
- Accepts operation commands over a valid/ready handshake and reads operands from a small internal register file.
- Drives the ALSU's A, B, S and Cin inputs for one execute cycle, captures F and Cout, writes F back to the register file, and returns a response over a second valid/ready handshake.
- Sits between the command source (test sequencer / microcode) and the combinational ALSU.

---
 rtl/alsu_issue_ctrl.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/alsu_issue_ctrl.sv
// alsu_issue_ctrl: issue controller for a combinational 4-bit ALSU.
// Accepts a command, reads both operands from a small register file, drives
// the ALSU for one EXEC cycle, writes the result back and holds a response
// until it is consumed. Build macro ALSU_OPCNT_EN adds the op_cnt[7:0]
// handshake counter output.
module alsu_issue_ctrl #(
  parameter int DATA_W = 4,
  parameter int NREG   = 4
) (
  input  logic                     clk,
  input  logic                     rst,
`ifdef ALSU_OPCNT_EN
  output logic [7:0]               op_cnt,
`endif
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [3:0]               cmd_op,
  input  logic [$clog2(NREG)-1:0]  cmd_srca,
  input  logic [$clog2(NREG)-1:0]  cmd_srcb,
  input  logic [$clog2(NREG)-1:0]  cmd_dst,
  input  logic                     cmd_cin,
  input  logic                     ld_valid,
  input  logic [$clog2(NREG)-1:0]  ld_addr,
  input  logic [DATA_W-1:0]        ld_data,
  output logic [DATA_W-1:0]        alsu_a,
  output logic [DATA_W-1:0]        alsu_b,
  output logic [3:0]               alsu_s,
  output logic                     alsu_cin,
  input  logic [DATA_W-1:0]        alsu_f,
  input  logic                     alsu_cout,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [DATA_W-1:0]        rsp_f,
  output logic                     rsp_cout,
  output logic                     rsp_zero,
  output logic                     rsp_err
);

  localparam int AW = $clog2(NREG);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [3:0]          op_q;
  logic [AW-1:0]       dst_q;
  logic                cin_q;
  logic [DATA_W-1:0]   a_q, b_q;
  logic [DATA_W-1:0]   rsp_f_q;
  logic                rsp_cout_q, rsp_zero_q, rsp_err_q;
  logic [DATA_W-1:0]   rf_rd [NREG];

  logic accept;
  logic in_exec;
  logic op_legal;
  logic wb_en;

  assign accept   = cmd_valid & cmd_ready;
  assign in_exec  = (state_q == EXEC);
  // 1110 and 1111 are the only illegal opcodes
  assign op_legal = ~(&op_q[3:1]);
  assign wb_en    = in_exec & op_legal;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state and handshake outputs
  always_comb begin
    state_d   = state_q;
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_d = EXEC;
      end
      EXEC: state_d = RESP;
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Register file: one entry per generate slice; EXEC writeback beats a same-edge load
  for (genvar gi = 0; gi < NREG; gi++) begin : g_rf
    logic [DATA_W-1:0] entry_q;
    always_ff @(posedge clk or posedge rst) begin
      if (rst)                                  entry_q <= '0;
      else if (wb_en && (dst_q == AW'(gi)))     entry_q <= alsu_f;
      else if (ld_valid && (ld_addr == AW'(gi))) entry_q <= ld_data;
    end
    assign rf_rd[gi] = entry_q;
  end

  // Latch the command and its operands on accept (operands read pre-edge values)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q  <= '0;
      dst_q <= '0;
      cin_q <= 1'b0;
      a_q   <= '0;
      b_q   <= '0;
    end else if (accept) begin
      op_q  <= cmd_op;
      dst_q <= cmd_dst;
      cin_q <= cmd_cin;
      a_q   <= rf_rd[cmd_srca];
      b_q   <= rf_rd[cmd_srcb];
    end
  end

  // Capture the ALSU result at the end of EXEC; illegal ops report a forced zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_f_q    <= '0;
      rsp_cout_q <= 1'b0;
      rsp_zero_q <= 1'b0;
      rsp_err_q  <= 1'b0;
    end else if (in_exec) begin
      rsp_f_q    <= op_legal ? alsu_f : '0;
      rsp_cout_q <= op_legal & alsu_cout;
      rsp_zero_q <= op_legal ? (alsu_f == '0) : 1'b1;
      rsp_err_q  <= ~op_legal;
    end
  end

`ifdef ALSU_OPCNT_EN
  logic [7:0] op_cnt_q;

  // Count every consumed response, error responses included; wraps naturally
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                        op_cnt_q <= 8'd0;
    else if (rsp_valid & rsp_ready) op_cnt_q <= op_cnt_q + 8'd1;
  end

  assign op_cnt = op_cnt_q;
`endif

  assign alsu_a   = in_exec ? a_q : '0;
  assign alsu_b   = in_exec ? b_q : '0;
  assign alsu_s   = in_exec ? op_q : 4'd0;
  assign alsu_cin = in_exec & cin_q;

  assign rsp_f    = rsp_f_q;
  assign rsp_cout = rsp_cout_q;
  assign rsp_zero = rsp_zero_q;
  assign rsp_err  = rsp_err_q;

endmodule
